// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage : PC register, imem address and IF/ID pipeline register.
// Optional perf counters enabled by `define FETCH_PERF_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pcF,
   output logic [31:0] pcD,
   output logic [31:0] pc4D,
   output logic [31:0] instD,
   output logic        validD,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   logic [31:0] pc_q,    pc_d;
   logic [31:0] inst_q,  inst_d;
   logic [31:0] pcd_q,   pcd_d;
   logic [31:0] pc4d_q,  pc4d_d;
   logic        valid_q, valid_d;
   logic        load_d;
   logic        unused_target_bits;

   assign unused_target_bits = ^br_target[1:0];
   assign load_d = !FlushD && !StallD;

   always_comb begin
      pc_d = pc_q + 32'd4;
      if (br_taken)
         pc_d = {br_target[31:2], 2'b00};
      else if (StallF)
         pc_d = pc_q;
   end

   // Flush outranks stall: a squashed instruction must never be held in decode.
   always_comb begin
      inst_d  = inst_q;
      pcd_d   = pcd_q;
      pc4d_d  = pc4d_q;
      valid_d = valid_q;
      if (FlushD) begin
         inst_d  = NOP_INSTR;
         pcd_d   = 32'd0;
         pc4d_d  = 32'd0;
         valid_d = 1'b0;
      end else if (!StallD) begin
         inst_d  = imem_rdata;
         pcd_d   = pc_q;
         pc4d_d  = pc_q + 32'd4;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= {RESET_PC[31:2], 2'b00};
         inst_q  <= NOP_INSTR;
         pcd_q   <= 32'd0;
         pc4d_q  <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         pcd_q   <= pcd_d;
         pc4d_q  <= pc4d_d;
         valid_q <= valid_d;
      end
   end

   assign imem_addr = pc_q;
   assign pcF       = pc_q;
   assign pcD       = pcd_q;
   assign pc4D      = pc4d_q;
   assign instD     = inst_q;
   assign validD    = valid_q;

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q + {31'd0, load_d};
      stall_cnt_d = stall_cnt_q + {31'd0, StallD && !FlushD};
      flush_cnt_d = flush_cnt_q + {31'd0, FlushD};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= 32'd0;
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   logic unused_load;
   assign unused_load = load_d;
   assign fetch_cnt   = 32'd0;
   assign stall_cnt   = 32'd0;
   assign flush_cnt   = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage : directed table, corner sequences and random run vs model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] CI  = 32'h0010_0093;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stall_f, stall_d, flush_d, br_taken;
   logic [31:0] br_target;
   logic        const_mode;

   logic [31:0] imem_addr, imem_rdata, pcF, pcD, pc4D, instD;
   logic [31:0] fetch_cnt, stall_cnt, flush_cnt;
   logic        validD;

   logic [31:0] imem_addr_w, pcF_w, pcD_w, pc4D_w, instD_w;
   logic [31:0] fetch_cnt_w, stall_cnt_w, flush_cnt_w;
   logic        validD_w;

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] mem_at(input logic mode, input logic [31:0] a);
      return mode ? CI : ((a * 32'h9E37_79B1) ^ 32'h0000_0005);
   endfunction

   always_comb imem_rdata = mem_at(const_mode, imem_addr);

   fetch_stage dut (
      .clk(clk), .rst(rst), .StallF(stall_f), .StallD(stall_d), .FlushD(flush_d),
      .br_taken(br_taken), .br_target(br_target), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .pcF(pcF), .pcD(pcD), .pc4D(pc4D), .instD(instD),
      .validD(validD), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst), .StallF(stall_f), .StallD(stall_d), .FlushD(flush_d),
      .br_taken(br_taken), .br_target(br_target), .imem_addr(imem_addr_w),
      .imem_rdata(CI), .pcF(pcF_w), .pcD(pcD_w), .pc4D(pc4D_w), .instD(instD_w),
      .validD(validD_w), .fetch_cnt(fetch_cnt_w), .stall_cnt(stall_cnt_w),
      .flush_cnt(flush_cnt_w)
   );

   // Reference model: architectural state of the stage, stepped once per edge.
   logic [31:0] m_pc, m_inst, m_pcd, m_pc4d, m_fc, m_sc, m_flc;
   logic        m_valid;

   task automatic model_edge();
      logic [31:0] npc;
      if (rst) begin
         m_pc = 32'd0; m_inst = NOP; m_pcd = 0; m_pc4d = 0; m_valid = 0;
         m_fc = 0; m_sc = 0; m_flc = 0;
      end else begin
         npc = br_taken ? (br_target & 32'hFFFF_FFFC) : (stall_f ? m_pc : m_pc + 32'd4);
         if (flush_d) begin
            m_inst = NOP; m_pcd = 0; m_pc4d = 0; m_valid = 0;
            m_flc = m_flc + 1;
         end else if (stall_d) begin
            m_sc = m_sc + 1;
         end else begin
            m_inst = mem_at(const_mode, m_pc); m_pcd = m_pc; m_pc4d = m_pc + 32'd4;
            m_valid = 1; m_fc = m_fc + 1;
         end
         m_pc = npc;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("pcF", pcF, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("pcD", pcD, m_pcd);
      chk("pc4D", pc4D, m_pc4d);
      chk("instD", instD, m_inst);
      chk("validD", {31'd0, validD}, {31'd0, m_valid});
`ifdef FETCH_PERF_EN
      chk("fetch_cnt", fetch_cnt, m_fc);
      chk("stall_cnt", stall_cnt, m_sc);
      chk("flush_cnt", flush_cnt, m_flc);
`else
      chk("fetch_cnt", fetch_cnt, 32'd0);
      chk("stall_cnt", stall_cnt, 32'd0);
      chk("flush_cnt", flush_cnt, 32'd0);
`endif
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic drive(input logic r, input logic sf, input logic sd, input logic fd,
                        input logic bt, input logic [31:0] tg);
      rst = r; stall_f = sf; stall_d = sd; flush_d = fd; br_taken = bt; br_target = tg;
   endtask

   typedef struct {
      logic        r, sf, sd, fd, bt;
      logic [31:0] tg;
      logic [31:0] e_pcf, e_pcd, e_pc4d, e_inst;
      logic        e_valid;
   } vec_t;

   vec_t vecs[12];

   initial begin
      const_mode = 1'b1;
      drive(1, 0, 0, 0, 0, 0);

      // Wrap: RESET_PC=FFFF_FFFC instance steps to 0 on its first free edge.
      step();
      chk("wrap_rst_pcF", pcF_w, 32'hFFFF_FFFC);
      chk("wrap_rst_instD", instD_w, NOP);
      drive(0, 0, 0, 0, 0, 0);
      step();
      chk("wrap_pcF", pcF_w, 32'h0000_0000);
      chk("wrap_pcD", pcD_w, 32'hFFFF_FFFC);
      chk("wrap_pc4D", pc4D_w, 32'h0000_0000);

      //         r  sf sd fd bt  target          pcF         pcD         pc4D        instD valid
      vecs[0]  = '{1, 0, 0, 0, 0, 32'h0,   32'h000,    32'h000,    32'h000,    NOP, 0};
      vecs[1]  = '{0, 0, 0, 0, 0, 32'h0,   32'h004,    32'h000,    32'h004,    CI,  1};
      vecs[2]  = '{0, 0, 0, 0, 0, 32'h0,   32'h008,    32'h004,    32'h008,    CI,  1};
      vecs[3]  = '{0, 1, 1, 0, 0, 32'h0,   32'h008,    32'h004,    32'h008,    CI,  1};
      vecs[4]  = '{0, 1, 1, 0, 0, 32'h0,   32'h008,    32'h004,    32'h008,    CI,  1};
      vecs[5]  = '{0, 0, 0, 0, 0, 32'h0,   32'h00C,    32'h008,    32'h00C,    CI,  1};
      vecs[6]  = '{0, 1, 0, 1, 1, 32'h103, 32'h100,    32'h000,    32'h000,    NOP, 0};
      vecs[7]  = '{0, 0, 0, 0, 0, 32'h0,   32'h104,    32'h100,    32'h104,    CI,  1};
      vecs[8]  = '{0, 0, 1, 1, 0, 32'h0,   32'h108,    32'h000,    32'h000,    NOP, 0};
      vecs[9]  = '{0, 0, 0, 0, 0, 32'h0,   32'h10C,    32'h108,    32'h10C,    CI,  1};
      vecs[10] = '{0, 1, 1, 0, 0, 32'h0,   32'h10C,    32'h108,    32'h10C,    CI,  1};
      vecs[11] = '{1, 1, 1, 0, 1, 32'h40,  32'h000,    32'h000,    32'h000,    NOP, 0};

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].r, vecs[i].sf, vecs[i].sd, vecs[i].fd, vecs[i].bt, vecs[i].tg);
         step();
         chk($sformatf("vec%0d_pcF", i), pcF, vecs[i].e_pcf);
         chk($sformatf("vec%0d_pcD", i), pcD, vecs[i].e_pcd);
         chk($sformatf("vec%0d_pc4D", i), pc4D, vecs[i].e_pc4d);
         chk($sformatf("vec%0d_instD", i), instD, vecs[i].e_inst);
         chk($sformatf("vec%0d_validD", i), {31'd0, validD}, {31'd0, vecs[i].e_valid});
`ifdef FETCH_PERF_EN
         if (i == 4) chk("vec4_stall_cnt", stall_cnt, 32'd2);
         if (i == 2) chk("vec2_fetch_cnt", fetch_cnt, 32'd2);
         if (i == 6) chk("vec6_flush_cnt", flush_cnt, 32'd1);
`endif
      end

      // StallF alone: PC holds and decode reloads the same instruction.
      const_mode = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      step();
      step();
      drive(0, 1, 0, 0, 0, 0);
      step();
      chk("stallf_only_pcF", pcF, 32'h008);
      chk("stallf_only_pcD", pcD, 32'h008);
      step();
      chk("stallf_only_again_pcD", pcD, 32'h008);
      chk("stallf_only_instD", instD, (32'h008 * 32'h9E37_79B1) ^ 32'h5);

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         logic st;
         st = ($urandom_range(0, 5) == 0);
         drive($urandom_range(0, 149) == 0,
               st | ($urandom_range(0, 19) == 0),
               st | ($urandom_range(0, 19) == 0),
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) == 0,
               $urandom());
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
